// File: rtl/regfile_sb_pkg.sv
// Shared core definitions for the integer register file and its scoreboard.
package regfile_sb_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_DEFAULT = 32;
  localparam int REG_ZERO     = 0;

  typedef logic [$clog2(NREG_DEFAULT)-1:0] reg_addr_t;
  typedef logic [XLEN_DEFAULT-1:0]         xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking: hazard detection for ID issue, release on WB write, flush clear.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter  int NREG = NREG_DEFAULT,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          rs1_en,
  input  logic [AW-1:0] rs1_addr,
  input  logic          rs2_en,
  input  logic [AW-1:0] rs2_addr,
  input  logic          issue_valid,
  input  logic          issue_rd_we,
  input  logic [AW-1:0] issue_rd,
  input  logic          flush,
  output logic          issue_ready,
  output logic [AW:0]   pending_cnt
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] wr_hit;
  logic [NREG-1:0] eb;
  logic [AW:0]     pending_q;

  always_comb begin
    wr_hit = '0;
    if (wr_en) wr_hit[wr_addr] = 1'b1;
    // a write landing this cycle frees its register immediately
    eb = busy_q & ~wr_hit;
    eb[REG_ZERO] = 1'b0;

    issue_ready = !reset
                  && !(rs1_en && eb[rs1_addr])
                  && !(rs2_en && eb[rs2_addr])
                  && !(issue_rd_we && eb[issue_rd]);

    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      busy_d = busy_q & ~wr_hit;
      if (issue_valid && issue_ready && issue_rd_we && issue_rd != AW'(REG_ZERO))
        busy_d[issue_rd] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q    <= '0;
      pending_q <= '0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= (AW+1)'($countones(busy_d));
    end
  end

  assign pending_cnt = pending_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file (2 async reads, 1 sync write) with issue scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle WB data onto the read ports.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter  int XLEN = XLEN_DEFAULT,
  parameter  int NREG = NREG_DEFAULT,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            rs1_en,
  input  logic [AW-1:0]   rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  input  logic            rs2_en,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  input  logic            issue_valid,
  input  logic            issue_rd_we,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  input  logic            flush,
  output logic [AW:0]     pending_cnt
);

  logic [XLEN-1:0] regs_q [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en && wr_addr != AW'(REG_ZERO)) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic en, input logic [AW-1:0] addr);
    logic [XLEN-1:0] v;
    v = '0;
    if (!reset && en && addr != AW'(REG_ZERO)) begin
      v = regs_q[addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && wr_addr == addr) v = wr_data;
`endif
    end
    return v;
  endfunction

  always_comb begin
    rs1_data = read_port(rs1_en, rs1_addr);
    rs2_data = read_port(rs2_en, rs2_addr);
  end

  regfile_scoreboard #(.NREG(NREG)) u_sb (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .rs1_en      (rs1_en),
    .rs1_addr    (rs1_addr),
    .rs2_en      (rs2_en),
    .rs2_addr    (rs2_addr),
    .issue_valid (issue_valid),
    .issue_rd_we (issue_rd_we),
    .issue_rd    (issue_rd),
    .flush       (flush),
    .issue_ready (issue_ready),
    .pending_cnt (pending_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus random traffic against an array-based model.
// Expected read data follows REGFILE_BYPASS_EN the same way the design build does.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            rs1_en, rs2_en;
  logic [AW-1:0]   rs1_addr, rs2_addr;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            issue_valid, issue_rd_we;
  logic [AW-1:0]   issue_rd;
  logic            issue_ready;
  logic            flush;
  logic [AW:0]     pending_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs1_en(rs1_en), .rs1_addr(rs1_addr), .rs1_data(rs1_data),
    .rs2_en(rs2_en), .rs2_addr(rs2_addr), .rs2_data(rs2_data),
    .issue_valid(issue_valid), .issue_rd_we(issue_rd_we), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .flush(flush), .pending_cnt(pending_cnt)
  );

  // ---------------- behavioural model ----------------
  logic [XLEN-1:0] mdl_reg  [NREG];
  bit              mdl_busy [NREG];
  bit              mdl_acc;

  function automatic bit eff_busy(input int a);
    return (a != 0) && mdl_busy[a] && !(wr_en && int'(wr_addr) == a);
  endfunction

  function automatic bit exp_ready();
    if (reset) return 1'b0;
    if (rs1_en && eff_busy(int'(rs1_addr))) return 1'b0;
    if (rs2_en && eff_busy(int'(rs2_addr))) return 1'b0;
    if (issue_rd_we && eff_busy(int'(issue_rd))) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [XLEN-1:0] exp_read(input logic en, input int a);
    if (reset || !en || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && int'(wr_addr) == a) return wr_data;
`endif
    return mdl_reg[a];
  endfunction

  function automatic int exp_pending();
    int n = 0;
    for (int i = 0; i < NREG; i++) if (mdl_busy[i]) n++;
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        mdl_reg[i]  = '0;
        mdl_busy[i] = 1'b0;
      end
    end else begin
      mdl_acc = issue_valid && exp_ready();
      if (wr_en && wr_addr != 0) mdl_reg[wr_addr] = wr_data;
      if (flush) begin
        for (int i = 0; i < NREG; i++) mdl_busy[i] = 1'b0;
      end else begin
        if (wr_en) mdl_busy[wr_addr] = 1'b0;
        if (mdl_acc && issue_rd_we && issue_rd != 0) mdl_busy[issue_rd] = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cmp_rs1_data", 64'(rs1_data), 64'(exp_read(rs1_en, int'(rs1_addr))));
    chk("cmp_rs2_data", 64'(rs2_data), 64'(exp_read(rs2_en, int'(rs2_addr))));
    chk("cmp_issue_ready", 64'(issue_ready), 64'(exp_ready()));
    chk("cmp_pending_cnt", 64'(pending_cnt), 64'(exp_pending()));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; wr_addr = 0; wr_data = 0;
    rs1_en = 0; rs1_addr = 0; rs2_en = 0; rs2_addr = 0;
    issue_valid = 0; issue_rd_we = 0; issue_rd = 0; flush = 0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #2;
    chk("rst_rs1", 64'(rs1_data), 64'h0);
    chk("rst_ready", 64'(issue_ready), 64'h0);
    chk("rst_pending", 64'(pending_cnt), 64'h0);
    step(); step();
    reset = 1'b0;

    // reads of x5 and x0 after reset
    rs1_en = 1; rs1_addr = 5; rs2_en = 1; rs2_addr = 0;
    #1;
    chk("post_rst_rs1_x5", 64'(rs1_data), 64'h0);
    chk("post_rst_rs2_x0", 64'(rs2_data), 64'h0);
    chk("post_rst_pending", 64'(pending_cnt), 64'h0);
    chk("post_rst_ready", 64'(issue_ready), 64'h1);

    // write x7, read back; write x0 is dropped
    step();
    wr_en = 1; wr_addr = 7; wr_data = 32'hDEADBEEF;
    step();
    wr_en = 1; wr_addr = 0; wr_data = 32'h1234; rs1_addr = 7;
    #1;
    chk("rd_x7", 64'(rs1_data), 64'hDEADBEEF);
    step();
    wr_en = 0; rs2_addr = 0;
    #1;
    chk("rd_x0_after_write", 64'(rs2_data), 64'h0);

    // RAW hazard on x3, released by WB in the same cycle
    idle();
    issue_valid = 1; issue_rd_we = 1; issue_rd = 3;
    #1;
    chk("issue_x3_ready", 64'(issue_ready), 64'h1);
    step();
    issue_rd_we = 0; rs1_en = 1; rs1_addr = 3;
    #1;
    chk("raw_x3_blocked", 64'(issue_ready), 64'h0);
    chk("raw_x3_pending", 64'(pending_cnt), 64'h1);
    wr_en = 1; wr_addr = 3; wr_data = 32'h55;
    #1;
    chk("raw_x3_released", 64'(issue_ready), 64'h1);
`ifdef REGFILE_BYPASS_EN
    chk("raw_x3_bypass", 64'(rs1_data), 64'h55);
`else
    chk("raw_x3_old", 64'(rs1_data), 64'h0);
`endif
    step();
    idle();
    rs1_en = 1; rs1_addr = 3;
    #1;
    chk("x3_reread", 64'(rs1_data), 64'h55);
    chk("x3_pending_zero", 64'(pending_cnt), 64'h0);

    // WAW: write to x4 and a new producer of x4 in the same cycle
    idle();
    issue_valid = 1; issue_rd_we = 1; issue_rd = 4;
    step();
    wr_en = 1; wr_addr = 4; wr_data = 32'hA5A5;
    #1;
    chk("waw_x4_ready", 64'(issue_ready), 64'h1);
    step();
    idle();
    issue_rd_we = 1; issue_rd = 4;
    #1;
    chk("waw_x4_pending", 64'(pending_cnt), 64'h1);
    chk("waw_x4_still_busy", 64'(issue_ready), 64'h0);
    wr_en = 1; wr_addr = 4;
    step();
    idle();

    // flush beats a simultaneous issue
    issue_valid = 1; issue_rd_we = 1;
    issue_rd = 1; step();
    issue_rd = 2; step();
    issue_rd = 9; step();
    issue_valid = 0;
    #1;
    chk("three_busy", 64'(pending_cnt), 64'h3);
    flush = 1; issue_valid = 1; issue_rd = 10;
    step();
    flush = 0; issue_valid = 0;
    #1;
    chk("flush_pending", 64'(pending_cnt), 64'h0);
    chk("flush_x10_free", 64'(issue_ready), 64'h1);
    idle();

    // random traffic checked by the compare process
    for (int n = 0; n < 2000; n++) begin
      step();
      wr_en       = ($urandom_range(0, 9) < 4);
      wr_addr     = AW'($urandom);
      wr_data     = $urandom;
      rs1_en      = ($urandom_range(0, 3) != 0);
      rs1_addr    = AW'($urandom);
      rs2_en      = ($urandom_range(0, 3) != 0);
      rs2_addr    = AW'($urandom);
      issue_valid = $urandom_range(0, 1) == 1;
      issue_rd_we = ($urandom_range(0, 9) < 7);
      issue_rd    = AW'($urandom);
      flush       = ($urandom_range(0, 31) == 0);
    end
    step();
    idle();

    // async reset mid-cycle with two busy registers and x7 written
    flush = 1;
    step();
    flush = 0; issue_valid = 1; issue_rd_we = 1; issue_rd = 11;
    step();
    issue_rd = 12;
    step();
    issue_valid = 0; issue_rd_we = 0;
    wr_en = 1; wr_addr = 7; wr_data = 32'hCAFE;
    step();
    wr_en = 0; rs1_en = 1; rs1_addr = 7;
    #1;
    chk("pre_rst_pending", 64'(pending_cnt), 64'h2);
    chk("pre_rst_x7", 64'(rs1_data), 64'hCAFE);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_rs1", 64'(rs1_data), 64'h0);
    chk("async_rst_ready", 64'(issue_ready), 64'h0);
    chk("async_rst_pending", 64'(pending_cnt), 64'h0);
    step(); step();
    reset = 1'b0;
    issue_rd_we = 1; issue_rd = 11;
    #1;
    chk("after_rst_x7", 64'(rs1_data), 64'h0);
    chk("after_rst_x11_free", 64'(issue_ready), 64'h1);
    chk("after_rst_pending", 64'(pending_cnt), 64'h0);
    step();
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
